depacketizer_fifo: RTL and testbench
====================================

Name: depacketizer_fifo

Overview:
- Receive-side endpoint between a fabric_interface output port and a compute unit such as mult_a or add_c.
- Accepts single-packet messages from the NoC and validates the header against this node's ID.
- Strips the header and buffers payloads in a DEPTH-entry first-word-fall-through FIFO with ready/valid on both sides.
- Malformed or misrouted packets are dropped and counted; they are never delivered to the compute unit.

Parameters:
- ADDRESS_WIDTH, 4: width of the node address field.
- VC_ADDRESS_WIDTH, 1: width of the VC field.
- WIDTH_PKT, 512: packet width from the NoC.
- WIDTH_DATA, 160: payload width.
- NODE_ID, 0: this node's address; packets for any other destination are dropped.
- DEPTH, 4: FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- i_packet_in  in  WIDTH_PKT  packet from the NoC.
- i_valid_in  in  1  packet valid.
- i_ready_out  out  1  block can accept a packet.
- o_data_out  out  WIDTH_DATA  payload at FIFO head.
- o_valid_out  out  1  FIFO non-empty.
- o_ready_in  in  1  consumer ready.
- o_err  out  1  one-cycle pulse when a packet is dropped.
- o_drop_count  out  16  saturating count of dropped packets.

Behaviour:
- Packet layout (fixed for this block):
  - bit WIDTH_PKT-1 = valid flag
  - WIDTH_PKT-2 = head
  - WIDTH_PKT-3 = tail
  - next VC_ADDRESS_WIDTH bits = vc (ignored)
  - next ADDRESS_WIDTH bits = dest
  - payload = packet[WIDTH_DATA-1:0]
  - Requires WIDTH_DATA+3+VC_ADDRESS_WIDTH+ADDRESS_WIDTH <= WIDTH_PKT; violating this is an elaboration error.
- Reset (rst=0, asynchronous):
  - FIFO emptied, wr/rd pointers = 0, count = 0.
  - i_ready_out = 0 while rst is asserted; it goes to 1 on the first clk edge after release.
  - o_valid_out = 0, o_err = 0, o_drop_count = 0, o_data_out = 0.
  - The same applies to a reset mid-traffic: all buffered data is discarded and nothing is partially delivered.
- Accept: a transfer occurs on a rising edge with i_valid_in=1 and i_ready_out=1. i_ready_out is registered and equals (count < DEPTH).
- Check of an accepted packet:
  - Good when valid flag=1, head=1, tail=1 and dest==NODE_ID.
  - Good: payload written at wr_ptr; wr_ptr increments modulo DEPTH.
  - Bad: nothing written; o_err=1 for exactly the next cycle; o_drop_count increments and holds at 0xFFFF.
- Output:
  - FWFT: o_valid_out = (count != 0), registered.
  - o_data_out = mem[rd_ptr].
  - Pop on o_valid_out & o_ready_in; rd_ptr increments modulo DEPTH.
  - o_data_out must be stable while o_valid_out=1 and o_ready_in=0.
- Latency: a good packet accepted at edge T is visible on o_valid_out/o_data_out after edge T (one cycle), provided the FIFO was empty.
- Count update per edge:
  - good push only: +1
  - pop only: -1
  - good push and pop together: unchanged
  - drop and pop together: -1
- Full: i_ready_out=0 and i_valid_in is ignored. A pop at full raises i_ready_out after the same edge. A push is never simultaneous with full.
- Empty: o_valid_out=0, o_ready_in is ignored, count never underflows.
- Throughput: one packet per cycle in and one payload per cycle out sustained when neither side stalls.
- Ordering: payloads leave in acceptance order. Pointer wrap-around must not reorder or duplicate entries.
- Arithmetic:
  - count is $clog2(DEPTH)+1 bits.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - Drop counter saturates, never wraps.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release. All outputs are 0 during reset; i_ready_out=1 one edge after release; o_drop_count=0.
- Single good packet: NODE_ID=0, dest=0, head=tail=valid=1, payload 0x...ABCD, o_ready_in=1. o_valid_out=1 one cycle after accept with data 0x...ABCD, then 0 the next cycle; o_err stays 0.
- Fill and wrap: o_ready_in=0, send 4 good packets (payloads 1..4). i_ready_out=0 after the 4th. Raise o_ready_in and push payloads 5..8 as space frees. Output sequence is 1..8 with no gaps or duplicates, and both pointers wrap once.
- Drops:
  - Send dest=3, then head=0, then valid flag=0, interleaved with two good packets (payloads 0x11, 0x22).
  - Exactly 3 o_err pulses; o_drop_count=3; output is 0x11 then 0x22 only.
- Simultaneous push/pop at count=2: count stays 2 and order is preserved. Force o_drop_count to 0xFFFE and send 3 bad packets: the counter reads 0xFFFF and stays there.
- Reset mid-traffic: with 3 entries buffered, assert rst asynchronously between edges. o_valid_out=0 immediately; after release no stale payload appears and a new packet 0x55 comes out first.

Source files
------------

// File: rtl/depacketizer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : depacketizer_fifo
//  Description : NoC receive endpoint. Validates single-flit packets against
//                NODE_ID, strips the header and buffers payloads in a
//                first-word-fall-through FIFO; bad packets are dropped and
//                counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module depacketizer_fifo #(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int WIDTH_PKT        = 512,
    parameter int WIDTH_DATA       = 160,
    parameter int NODE_ID          = 0,
    parameter int DEPTH            = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_PKT-1:0]  i_packet_in,
    input  logic                  i_valid_in,
    output logic                  i_ready_out,
    output logic [WIDTH_DATA-1:0] o_data_out,
    output logic                  o_valid_out,
    input  logic                  o_ready_in,
    output logic                  o_err,
    output logic [15:0]           o_drop_count
);

    localparam int c_ptr_w    = $clog2(DEPTH);
    localparam int c_cnt_w    = c_ptr_w + 1;
    localparam int c_vc_lsb   = WIDTH_PKT - 3 - VC_ADDRESS_WIDTH;
    localparam int c_dest_lsb = c_vc_lsb - ADDRESS_WIDTH;

    localparam logic [c_cnt_w-1:0]       c_depth    = c_cnt_w'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] c_node_id  = ADDRESS_WIDTH'(NODE_ID);
    localparam logic [15:0]              c_drop_max = 16'hFFFF;

    generate
        if (WIDTH_DATA + 3 + VC_ADDRESS_WIDTH + ADDRESS_WIDTH > WIDTH_PKT) begin : g_bad_layout
            $error("depacketizer_fifo: header and payload do not fit in WIDTH_PKT");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("depacketizer_fifo: DEPTH must be a power of 2 and at least 2");
        end
        // Bits between the header and the payload carry nothing for this block
        if (c_dest_lsb > WIDTH_DATA) begin : g_pad
            logic w_pad_unused;
            assign w_pad_unused = ^i_packet_in[c_dest_lsb-1:WIDTH_DATA];
        end
    endgenerate

    logic [WIDTH_DATA-1:0]       r_mem [DEPTH];
    logic [c_ptr_w-1:0]          r_wr_ptr;
    logic [c_ptr_w-1:0]          r_rd_ptr;
    logic [c_cnt_w-1:0]          r_count;
    logic                        r_ready;
    logic                        r_valid;
    logic                        r_err;
    logic [15:0]                 r_drop_count;

    logic [ADDRESS_WIDTH-1:0]    w_dest;
    logic [VC_ADDRESS_WIDTH-1:0] w_vc_unused;
    logic                        w_good;
    logic                        w_accept;
    logic                        w_push;
    logic                        w_drop;
    logic                        w_pop;
    logic [c_cnt_w-1:0]          w_count_next;

    assign w_dest      = i_packet_in[c_dest_lsb +: ADDRESS_WIDTH];
    assign w_vc_unused = i_packet_in[c_vc_lsb +: VC_ADDRESS_WIDTH];

    assign w_good   = i_packet_in[WIDTH_PKT-1] & i_packet_in[WIDTH_PKT-2]
                    & i_packet_in[WIDTH_PKT-3] & (w_dest == c_node_id);
    assign w_accept = i_valid_in & r_ready;
    assign w_push   = w_accept & w_good;
    assign w_drop   = w_accept & ~w_good;
    assign w_pop    = r_valid & o_ready_in;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_cnt_w'(1);
            2'b01:   w_count_next = r_count - c_cnt_w'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Ready and valid are registered from the next count so both sides see
    // flop outputs while still tracking occupancy exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_ready      <= 1'b0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_packet_in[WIDTH_DATA-1:0];
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next < c_depth);
            r_valid <= (w_count_next != '0);
            r_err   <= w_drop;
            if (w_drop && r_drop_count != c_drop_max) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign i_ready_out  = r_ready;
    assign o_valid_out  = r_valid;
    assign o_data_out   = r_mem[r_rd_ptr];
    assign o_err        = r_err;
    assign o_drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_depacketizer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_depacketizer_fifo
//  Description : Randomized scoreboard bench for depacketizer_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_depacketizer_fifo;

    localparam int AW    = 4;
    localparam int VCW   = 1;
    localparam int WP    = 512;
    localparam int WD    = 160;
    localparam int NID   = 0;
    localparam int DEPTH = 4;
    localparam int DEST_LSB = WP - 3 - VCW - AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [WP-1:0] i_packet_in = '0;
    logic          i_valid_in = 1'b0;
    logic          i_ready_out;
    logic [WD-1:0] o_data_out;
    logic          o_valid_out;
    logic          o_ready_in = 1'b0;
    logic          o_err;
    logic [15:0]   o_drop_count;

    depacketizer_fifo #(
        .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VCW), .WIDTH_PKT(WP),
        .WIDTH_DATA(WD), .NODE_ID(NID), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .i_packet_in(i_packet_in), .i_valid_in(i_valid_in), .i_ready_out(i_ready_out),
        .o_data_out(o_data_out), .o_valid_out(o_valid_out), .o_ready_in(o_ready_in),
        .o_err(o_err), .o_drop_count(o_drop_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic armed = 1'b0;

    // Reference model: payloads currently held by the FIFO, in order
    logic [WD-1:0] sb[$];
    logic          exp_err  = 1'b0;
    logic [15:0]   exp_drop = 16'd0;

    task automatic chk(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WD-1:0] rand_pl();
        logic [WD-1:0] d;
        for (int i = 0; i < WD / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [WP-1:0] mk_pkt(input logic v, input logic h, input logic t,
                                             input logic [AW-1:0] dest, input logic [WD-1:0] pl);
        logic [WP-1:0] p;
        for (int i = 0; i < WP / 32; i++) p[i*32 +: 32] = $urandom;
        p[WP-1] = v;
        p[WP-2] = h;
        p[WP-3] = t;
        p[DEST_LSB +: AW] = dest;
        p[WD-1:0] = pl;
        return p;
    endfunction

    function automatic logic [WP-1:0] good_pkt(input logic [WD-1:0] pl);
        return mk_pkt(1'b1, 1'b1, 1'b1, AW'(NID), pl);
    endfunction

    // kind 0: wrong dest, 1: head=0, 2: tail=0, 3: valid flag=0
    function automatic logic [WP-1:0] bad_pkt(input int kind, input logic [WD-1:0] pl);
        logic [AW-1:0] wrong;
        wrong = AW'(NID + $urandom_range(1, (1 << AW) - 1));
        case (kind)
            0:       return mk_pkt(1'b1, 1'b1, 1'b1, wrong, pl);
            1:       return mk_pkt(1'b1, 1'b0, 1'b1, AW'(NID), pl);
            2:       return mk_pkt(1'b1, 1'b1, 1'b0, AW'(NID), pl);
            default: return mk_pkt(1'b0, 1'b1, 1'b1, AW'(NID), pl);
        endcase
    endfunction

    function automatic logic is_good(input logic [WP-1:0] p);
        return p[WP-1] && p[WP-2] && p[WP-3] && (p[DEST_LSB +: AW] == AW'(NID));
    endfunction

    // Monitor: compares what the DUT presents this cycle, then advances the
    // model by what will happen on the coming rising edge.
    always @(negedge clk) begin
        logic pop, acc, good;
        if (!armed) begin
            sb.delete();
            exp_err  = 1'b0;
            exp_drop = 16'd0;
        end else begin
            chk("o_valid_out", WD'(o_valid_out), WD'(sb.size() != 0));
            chk("i_ready_out", WD'(i_ready_out), WD'(sb.size() < DEPTH));
            chk("o_err", WD'(o_err), WD'(exp_err));
            chk("o_drop_count", WD'(o_drop_count), WD'(exp_drop));
            if (sb.size() != 0) chk("o_data_out", o_data_out, sb[0]);
            pop  = (sb.size() != 0) && o_ready_in;
            acc  = i_valid_in && (sb.size() < DEPTH);
            good = is_good(i_packet_in);
            if (pop) void'(sb.pop_front());
            if (acc && good) sb.push_back(i_packet_in[WD-1:0]);
            exp_err = acc && !good;
            if (acc && !good && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
        end
    end

    task automatic send(input logic [WP-1:0] p);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        i_packet_in = p;
        i_valid_in  = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = i_ready_out;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got not-accepted expected accepted at %0t", $time);
        end
        i_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        o_ready_in = 1'b1;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", WD'(sb.size()), WD'(0));
        idle(2);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", WD'(i_ready_out), WD'(1));
        chk("drop_after_release", WD'(o_drop_count), WD'(0));
        armed = 1'b1;
    endtask

    initial begin
        // Reset and idle
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_valid", WD'(o_valid_out), WD'(0));
            chk("rst_ready", WD'(i_ready_out), WD'(0));
            chk("rst_err", WD'(o_err), WD'(0));
            chk("rst_drop", WD'(o_drop_count), WD'(0));
            chk("rst_data", o_data_out, WD'(0));
        end
        release_reset();

        // Single good packet
        o_ready_in = 1'b1;
        send(good_pkt(WD'(20'hABCD)));
        idle(3);

        // Fill, then wrap while draining
        o_ready_in = 1'b0;
        for (int i = 1; i <= 4; i++) send(good_pkt(WD'(i)));
        o_ready_in = 1'b1;
        for (int i = 5; i <= 8; i++) send(good_pkt(WD'(i)));
        drain();

        // Drops interleaved with good traffic
        send(bad_pkt(0, rand_pl()));
        send(good_pkt(WD'(8'h11)));
        send(bad_pkt(1, rand_pl()));
        send(good_pkt(WD'(8'h22)));
        send(bad_pkt(3, rand_pl()));
        drain();
        chk("drop_count_3", WD'(o_drop_count), WD'(3));

        // Simultaneous push and pop at two entries
        o_ready_in = 1'b0;
        send(good_pkt(rand_pl()));
        send(good_pkt(rand_pl()));
        o_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) send(good_pkt(rand_pl()));
        drain();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int k;
            k = $urandom_range(0, 9);
            i_packet_in = (k < 4) ? bad_pkt(k, rand_pl()) : good_pkt(rand_pl());
            i_valid_in  = ($urandom_range(0, 3) != 0);
            o_ready_in  = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        i_valid_in = 1'b0;
        drain();

        // Asynchronous reset with three entries buffered
        o_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) send(good_pkt(rand_pl()));
        #2;
        rst   = 1'b0;
        armed = 1'b0;
        #1;
        chk("midrst_valid", WD'(o_valid_out), WD'(0));
        chk("midrst_ready", WD'(i_ready_out), WD'(0));
        chk("midrst_data", o_data_out, WD'(0));
        idle(2);
        release_reset();
        o_ready_in = 1'b1;
        send(good_pkt(WD'(8'h55)));
        drain();

        // Saturate the drop counter
        i_valid_in = 1'b1;
        for (int c = 0; c < 65540; c++) begin
            i_packet_in = bad_pkt($urandom_range(0, 3), rand_pl());
            @(posedge clk);
            #1;
        end
        i_valid_in = 1'b0;
        idle(2);
        chk("drop_saturated", WD'(o_drop_count), WD'(16'hFFFF));
        for (int i = 0; i < 3; i++) send(bad_pkt(i, rand_pl()));
        send(good_pkt(rand_pl()));
        drain();
        chk("drop_held", WD'(o_drop_count), WD'(16'hFFFF));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
